// File: rtl/fp_add_pipe.sv
// Three-stage single-precision adder (align, add, normalize/round/pack); result 3 cycles after accept,
// whole pipe freezes while out_valid && !out_ready. Define FP_ADD_RNE_EN for round-to-nearest-even, else truncation.
module fp_add_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] special_S,
  input  logic        special_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] S
);

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Stage 1: unpack, swap so X has the larger magnitude, align Y with G/R/S.
  logic [7:0]  ea, eb, x_exp, y_exp, d;
  logic [23:0] ma, mb, x_man, y_man;
  logic        a_big, x_sign, y_sign;
  logic [49:0] ext;
  logic [26:0] y_al;

  always_comb begin
    ea     = (A[30:23] == 8'd0) ? 8'd1 : A[30:23];
    eb     = (B[30:23] == 8'd0) ? 8'd1 : B[30:23];
    ma     = {(A[30:23] != 8'd0), A[22:0]};
    mb     = {(B[30:23] != 8'd0), B[22:0]};
    a_big  = {ea, ma} >= {eb, mb};
    x_sign = a_big ? A[31] : B[31];
    y_sign = a_big ? B[31] : A[31];
    x_exp  = a_big ? ea : eb;
    y_exp  = a_big ? eb : ea;
    x_man  = a_big ? ma : mb;
    y_man  = a_big ? mb : ma;
    d      = x_exp - y_exp;
    ext    = {y_man, 26'd0} >> d;
    y_al   = (d >= 8'd27) ? 27'd1 : {ext[49:24], |ext[23:0]};
  end

  logic        s1_valid, s1_sub, s1_sign, s1_spec_en;
  logic [7:0]  s1_exp;
  logic [26:0] s1_mx, s1_my;
  logic [31:0] s1_spec;

  // Stage 2: magnitude add/subtract; X >= Y so the difference never goes negative.
  logic [27:0] sum;
  always_comb begin
    sum = s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});
  end

  logic        s2_valid, s2_sign, s2_spec_en;
  logic [7:0]  s2_exp;
  logic [27:0] s2_sum;
  logic [31:0] s2_spec;

  // Stage 3: normalize, round, pack; exponents kept as 10-bit two's complement.
  logic [4:0]  lz;
  logic [26:0] norm;
  logic [9:0]  e_norm, e_rnd;
  logic [24:0] mant;
  logic        round_up;
  logic [31:0] res;

  always_comb begin
    lz = lzc27(s2_sum[26:0]);
    if (s2_sum[27]) begin
      norm   = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
      e_norm = {2'b00, s2_exp} + 10'd1;
    end else begin
      norm   = s2_sum[26:0] << lz;
      e_norm = {2'b00, s2_exp} - {5'd0, lz};
    end
`ifdef FP_ADD_RNE_EN
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    round_up = 1'b0;
`endif
    mant  = {1'b0, norm[26:3]} + {24'd0, round_up};
    e_rnd = e_norm + {9'd0, mant[24]};
    if (!s2_spec_en)                          res = s2_spec;
    else if (s2_sum == 28'd0)                 res = 32'd0;
    else if ($signed(e_norm) <= 10'sd0)       res = {s2_sign, 31'd0};
    else if ($signed(e_rnd) >= 10'sd255)      res = {s2_sign, 8'hFF, 23'd0};
    else                                      res = {s2_sign, e_rnd[7:0], mant[22:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sub     <= 1'b0;
      s1_sign    <= 1'b0;
      s1_spec_en <= 1'b0;
      s1_exp     <= 8'd0;
      s1_mx      <= 27'd0;
      s1_my      <= 27'd0;
      s1_spec    <= 32'd0;
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_spec_en <= 1'b0;
      s2_exp     <= 8'd0;
      s2_sum     <= 28'd0;
      s2_spec    <= 32'd0;
      out_valid  <= 1'b0;
      S          <= 32'd0;
    end else if (adv) begin
      s1_valid   <= in_valid;
      s1_sub     <= x_sign ^ y_sign;
      s1_sign    <= x_sign;
      s1_spec_en <= special_en;
      s1_exp     <= x_exp;
      s1_mx      <= {x_man, 3'b000};
      s1_my      <= y_al;
      s1_spec    <= special_S;
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_spec_en <= s1_spec_en;
      s2_exp     <= s1_exp;
      s2_sum     <= sum;
      s2_spec    <= s1_spec;
      out_valid  <= s2_valid;
      if (s2_valid) S <= res;
    end
  end

endmodule
